// File: rtl/serial_comp_ctrl.sv
// Two-requester round-robin front end for a bit-serial complementer: grants one word,
// streams it LSB first, collects the returned bits and holds the result until consumed.
// Optional macro SERIAL_COMP_TWOS_EN adds 1 serially so the result is the two's complement.
module serial_comp_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         ser_en,
    output logic         ser_o,
    input  logic         ser_i,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    output logic         res_id,
    input  logic         res_ready,
    output logic         busy
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  res_q, res_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          gnt1;
    logic          res_bit;
`ifdef SERIAL_COMP_TWOS_EN
    logic          carry_q, carry_d;
`endif

    always_comb begin
        // Requester 1 wins when it is alone, or on contention when 0 was served last.
        gnt1       = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == IDLE) & req0_valid & ~gnt1;
        req1_ready = (state_q == IDLE) & gnt1;

`ifdef SERIAL_COMP_TWOS_EN
        res_bit = ser_i ^ carry_q;
        carry_d = carry_q;
`else
        res_bit = ser_i;
`endif
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        res_d   = res_q;
        owner_d = owner_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    sh_d    = gnt1 ? req1_data : req0_data;
                    owner_d = gnt1;
                    cnt_d   = '0;
                    state_d = SHIFT;
`ifdef SERIAL_COMP_TWOS_EN
                    carry_d = 1'b1;
`endif
                end
            end
            SHIFT: begin
                sh_d  = sh_q >> 1;
                res_d = {res_bit, res_q[W-1:1]};
                cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_COMP_TWOS_EN
                carry_d = ser_i & carry_q;
`endif
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
`ifdef SERIAL_COMP_TWOS_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef SERIAL_COMP_TWOS_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign ser_en    = (state_q == SHIFT);
    assign ser_o     = ser_en & sh_q[0];
    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;
    assign res_id    = owner_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl: datapath modelled as ser_i = ~ser_o, a cycle-level
// behavioural model checked every cycle, plus directed transactions with literal results.
module tb_serial_comp_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         ser_en, ser_o, ser_i;
    logic         res_valid, res_id, res_ready, busy;
    logic [W-1:0] res_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    assign ser_i = ~ser_o;

    serial_comp_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_en(ser_en), .ser_o(ser_o), .ser_i(ser_i),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference transform: one's complement, or two's complement with the macro.
    function automatic logic [W-1:0] xform(input logic [W-1:0] x);
`ifdef SERIAL_COMP_TWOS_EN
        return W'(0) - x;
`else
        return ~x;
`endif
    endfunction

    function automatic logic [7:0] pick(input logic [7:0] ones, input logic [7:0] twos);
`ifdef SERIAL_COMP_TWOS_EN
        return twos;
`else
        return ones;
`endif
    endfunction

    // Model: m_age = cycles since acceptance (0 = idle, 1..W = bit cycles, W+1 = waiting).
    int           m_age  = 0;
    logic         m_last = 1'b1;
    logic         m_own  = 1'b0;
    logic [W-1:0] m_in   = '0;

    always @(negedge clk) begin
        logic g0, g1;
        #2;
        if (!rst) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_ser_en", ser_en, 0);
            chk("rst_ser_o", ser_o, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_data", res_data, 0);
            chk("rst_busy", busy, 0);
            m_age = 0; m_last = 1'b1; m_own = 1'b0;
        end else begin
            g0 = 1'b0; g1 = 1'b0;
            if (m_age == 0) begin
                if (req0_valid && req1_valid) begin
                    g0 = m_last; g1 = ~m_last;
                end else begin
                    g0 = req0_valid; g1 = req1_valid;
                end
            end
            chk("m_req0_ready", req0_ready, g0);
            chk("m_req1_ready", req1_ready, g1);
            chk("m_ser_en", ser_en, (m_age >= 1 && m_age <= W));
            chk("m_ser_o", ser_o, (m_age >= 1 && m_age <= W) ? m_in[m_age-1] : 1'b0);
            chk("m_res_valid", res_valid, (m_age == W + 1));
            chk("m_busy", busy, (m_age != 0));
            if (m_age == W + 1) begin
                chk("m_res_data", res_data, xform(m_in));
                chk("m_res_id", res_id, m_own);
            end
            if (m_age == 0) begin
                if (g0 || g1) begin
                    m_in  = g1 ? req1_data : req0_data;
                    m_own = g1;
                    m_age = 1;
                end
            end else if (m_age <= W) begin
                m_age++;
            end else if (res_ready) begin
                m_last = m_own;
                m_age  = 0;
            end
        end
        cyc++;
    end

    task automatic run(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1,
                       input logic id, input logic [7:0] exp, input int hold);
        int  t;
        bit  ok;
        logic [7:0] snap;
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        res_ready  = (hold == 0);
        #3;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            if (id ? (req1_ready && req1_valid) : (req0_ready && req0_valid)) begin
                ok = 1;
                break;
            end
            @(negedge clk); #3;
        end
        chk("accept_seen", ok, 1);
        t = cyc;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
            #3;
            if (res_valid) begin
                ok = 1;
                break;
            end
        end
        chk("res_valid_seen", ok, 1);
        chk("latency", cyc - t, 9);
        chk("res_data_lit", res_data, exp);
        chk("res_id_lit", res_id, id);
        if (hold > 0) begin
            snap = res_data;
            for (int j = 0; j < hold; j++) begin
                @(negedge clk); #3;
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, snap);
                chk("hold_id", res_id, id);
                chk("hold_busy", busy, 1);
                chk("hold_no_ready", req0_ready | req1_ready, 0);
            end
            @(negedge clk);
            res_ready = 1'b1;
            #3;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_res_data", res_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Contention straight out of reset: requester 0 first, then 1, then 0 wins again.
        run(1'b1, 8'h0F, 1'b1, 8'hF0, 1'b0, pick(8'hF0, 8'hF1), 0);
        run(1'b0, 8'h00, 1'b1, 8'hF0, 1'b1, pick(8'h0F, 8'h10), 0);
        run(1'b1, 8'h81, 1'b1, 8'h55, 1'b0, pick(8'h7E, 8'h7F), 0);
        run(1'b0, 8'h00, 1'b1, 8'h55, 1'b1, pick(8'hAA, 8'hAB), 0);

        run(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, pick(8'h5A, 8'h5B), 0);
        run(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, pick(8'hCC, 8'hCD), 5);
        run(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, pick(8'hFF, 8'h00), 0);
        run(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, pick(8'hFE, 8'hFF), 0);

        // Abort in the 4th bit cycle.
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'h77;
        #3;
        chk("abort_accept", req0_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req0_valid = 1'b0;
            #3;
        end
        chk("abort_pre_ser_en", ser_en, 1);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("abort_ser_en", ser_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_data", res_data, 0);
        @(negedge clk);
        rst = 1'b1;
        run(1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, pick(8'hC3, 8'hC4), 0);

        repeat (3) @(negedge clk);
        #3;
        chk("final_idle", busy, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
